// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared FSM state encoding and protocol byte constants for the UART command parser.
package uart_cmd_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CHK, RESP} state_t;
    localparam logic [7:0] CMD_WRITE    = 8'h57;
    localparam logic [7:0] CMD_READ     = 8'h52;
    localparam logic [7:0] RSP_ACK      = 8'h06;
    localparam logic [7:0] RSP_NAK      = 8'h15;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: UART receive/transmit handshake between the UART core (master) and the parser (slave).
interface uart_cmd_parser_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_byte;
    logic       i_rx_error;
    logic       i_tx_busy;
    logic       o_tx_valid;
    logic [7:0] o_tx_byte;
    modport master (output i_rx_valid, i_rx_byte, i_rx_error, i_tx_busy, input o_tx_valid, o_tx_byte);
    modport slave  (input i_rx_valid, i_rx_byte, i_rx_error, i_tx_busy, output o_tx_valid, o_tx_byte);
endinterface

// File: rtl/uart_cmd_regfile.sv
// uart_cmd_regfile: NumRegs x 8-bit register file with one write port, one read mux and a flattened view.
module uart_cmd_regfile #(
    parameter int NumRegs = 4
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       we,
    input  logic [$clog2(NumRegs)-1:0] waddr,
    input  logic [7:0]                 wdata,
    input  logic [$clog2(NumRegs)-1:0] raddr,
    output logic [7:0]                 rdata,
    output logic [NumRegs*8-1:0]       o_regs
);
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) o_regs <= '0;
        else if (we) o_regs[8*waddr +: 8] <= wdata;
    end

    assign rdata = o_regs[8*raddr +: 8];
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes SYNC/CMD/ADDR/DATA/CHK frames into register writes/reads and a one-byte reply.
// Optional inter-byte timeout when UART_CMD_PARSER_TIMEOUT_EN is defined.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         NumRegs       = 4,
    parameter logic [7:0] SyncByte      = SYNC_DEFAULT,
    parameter int         TimeoutCycles = 1562500
) (
    input  logic                 clk,
    input  logic                 i_rst,
    uart_cmd_parser_if.slave     uart,
    output logic [7:0]           o_led,
    output logic [NumRegs*8-1:0] o_regs,
    output logic [7:0]           o_err_cnt
);
    localparam int         AW    = $clog2(NumRegs);
    localparam logic [7:0] NREGS = 8'(NumRegs);

    state_t     state;
    logic [7:0] cmd, addr, data, rsp, rd_data, resp;
    logic       rx, nak, we, err_ev, timeout, busy;

    assign busy   = uart.i_tx_busy;
    assign rx     = uart.i_rx_valid && !uart.i_rx_error;
    assign nak    = (cmd ^ addr ^ data) != uart.i_rx_byte || (cmd != CMD_WRITE && cmd != CMD_READ) || addr >= NREGS;
    assign resp   = nak ? RSP_NAK : cmd == CMD_WRITE ? RSP_ACK : rd_data;
    assign we     = state == CHK && rx && !nak && cmd == CMD_WRITE;
    assign err_ev = state != IDLE && (uart.i_rx_error || timeout || (rx && (state == RESP || (state == CHK && nak))));
    assign o_led  = o_regs[7:0];

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] tmo_cnt;
    logic          active;
    assign active  = state inside {CMD, ADDR, DATA, CHK};
    assign timeout = active && !uart.i_rx_valid && tmo_cnt == TW'(TimeoutCycles - 1);
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) tmo_cnt <= '0;
        else tmo_cnt <= (uart.i_rx_valid || !active) ? '0 : tmo_cnt + 1'b1;
    end
`else
    assign timeout = TimeoutCycles < 0;
`endif

    uart_cmd_regfile #(.NumRegs(NumRegs)) u_regfile (
        .clk   (clk),
        .i_rst (i_rst),
        .we    (we),
        .waddr (addr[AW-1:0]),
        .wdata (data),
        .raddr (addr[AW-1:0]),
        .rdata (rd_data),
        .o_regs(o_regs)
    );

    // A reply is sent straight from CHK when the transmitter is free, otherwise held in rsp until it is.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            cmd             <= '0;
            addr            <= '0;
            data            <= '0;
            rsp             <= '0;
            o_err_cnt       <= '0;
            uart.o_tx_valid <= 1'b0;
            uart.o_tx_byte  <= '0;
        end else begin
            o_err_cnt       <= o_err_cnt + 8'(err_ev && o_err_cnt != 8'hFF);
            uart.o_tx_valid <= 1'b0;
            if (state != IDLE && (uart.i_rx_error || timeout)) state <= IDLE;
            else case (state)
                IDLE: if (rx && uart.i_rx_byte == SyncByte) state <= CMD;
                CMD:  if (rx) begin cmd  <= uart.i_rx_byte; state <= ADDR; end
                ADDR: if (rx) begin addr <= uart.i_rx_byte; state <= DATA; end
                DATA: if (rx) begin data <= uart.i_rx_byte; state <= CHK; end
                CHK: if (rx) begin
                    rsp             <= resp;
                    uart.o_tx_valid <= !busy;
                    if (!busy) uart.o_tx_byte <= resp;
                    state <= RESP;
                end
                RESP: begin
                    uart.o_tx_valid <= !uart.o_tx_valid && !busy;
                    if (!uart.o_tx_valid && !busy) uart.o_tx_byte <= rsp;
                    if (uart.o_tx_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Byte-stream command parser that sits directly downstream of the UART receiver and upstream of its transmitter.
- Consumes received bytes and decodes fixed 5-byte frames.
- Writes or reads a small 8-bit register file; register 0 drives the board LEDs.
- Returns a one-byte response through the UART transmit handshake. It replaces the direct received-byte-to-LED path in the top level.

Parameters:
- NumRegs, 4, number of 8-bit registers (2..16); register 0 is the LED register.
- SyncByte, 8'hA5, frame start marker.
- TimeoutCycles, 1562500, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_rx_valid  in  1  one-cycle pulse when a byte has been received (UART received)
- i_rx_byte  in  8  received byte, valid while i_rx_valid is high
- i_rx_error  in  1  UART receive framing error pulse
- i_tx_busy  in  1  UART transmitter busy (is_transmitting)
- o_tx_valid  out  1  one-cycle transmit request (UART transmit)
- o_tx_byte  out  8  response byte, held stable from the o_tx_valid cycle until the next response
- o_led  out  8  register 0 contents
- o_regs  out  NumRegs*8  all registers flattened; register k occupies bits [8k+7:8k]
- o_err_cnt  out  8  saturating count of NAKs plus aborted frames

Behaviour:
- Reset values (asynchronous, all outputs): every register 0; o_led 0; o_regs 0; o_tx_valid 0; o_tx_byte 0; o_err_cnt 0; FSM in IDLE.
- Frame format: SYNC, CMD, ADDR, DATA, CHK.
  - CHK = CMD ^ ADDR ^ DATA.
  - CMD 8'h57 ('W') is a write. CMD 8'h52 ('R') is a read; its DATA byte is don't-care but is included in CHK.
- FSM states: IDLE -> CMD -> ADDR -> DATA -> CHK -> RESP -> IDLE. Each arrow except RESP->IDLE advances on an i_rx_valid cycle.
- IDLE: a byte equal to SyncByte advances to CMD. Any other byte is ignored silently and is not counted.
- CMD, ADDR, DATA: latch the byte and advance. No validation happens until the CHK byte arrives.
- CHK byte received: evaluate the frame in the same cycle, then enter RESP.
  - NAK (8'h15) if the checksum mismatches, CMD is unknown, or ADDR >= NumRegs.
  - Otherwise a write updates the addressed register and responds ACK (8'h06).
  - Otherwise a read responds with the register value.
  - A NAK frame never modifies any register.
- Write timing: the register, o_regs and o_led update on the clock edge ending the CHK-byte cycle. Write latency is 1 cycle after the CHK i_rx_valid.
- RESP: assert o_tx_valid for exactly one cycle, on the first cycle with i_tx_busy == 0, then return to IDLE. Minimum response latency is 1 cycle after the CHK byte. There is no timeout on i_tx_busy.
- Bytes arriving while in RESP are dropped and counted in o_err_cnt.
- i_rx_error in any non-IDLE state: abort to IDLE, no response, increment o_err_cnt. In IDLE it is ignored.
- i_rx_error and i_rx_valid in the same cycle: the error wins and the byte is discarded.
- A SyncByte value inside the CMD, ADDR, DATA or CHK position is treated as ordinary data; there is no resync.
- o_err_cnt increments on every NAK, abort and dropped byte. It saturates at 8'hFF and does not wrap.
- Reset mid-frame or mid-RESP: the frame is discarded and no pending transmit is emitted after reset release.

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- When defined: a counter reloads on every i_rx_valid. If the FSM is in CMD, ADDR, DATA or CHK and TimeoutCycles cycles elapse with no byte, the FSM returns to IDLE, sends no response, and increments o_err_cnt. The counter is idle in IDLE and RESP.
- When undefined: no counter logic is present, and a partial frame waits indefinitely.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DATA, CHK, RESP);
  - constants CMD_WRITE 8'h57, CMD_READ 8'h52, RSP_ACK 8'h06, RSP_NAK 8'h15, SYNC_DEFAULT 8'hA5.
- Sub-module uart_cmd_regfile holds the NumRegs x 8 register array, write port, read mux and flattened output. The FSM stays in uart_cmd_parser.

Test Plan:
- Send A5 57 00 3C 6B -> o_led = 8'h3C one cycle after the last byte; o_tx_valid pulses once with o_tx_byte = 8'h06.
- Send A5 57 02 F0 A5, then A5 52 02 00 50 -> register 2 = 8'hF0; second response o_tx_byte = 8'hF0; o_led unchanged.
- Send A5 57 00 11 00 (bad CHK), then A5 57 07 11 41 with NumRegs = 4 -> two NAKs (8'h15); o_led unchanged; o_err_cnt = 2.
- Hold i_tx_busy = 1 for 1000 cycles around a valid frame's CHK byte -> o_tx_valid stays low and asserts exactly one cycle after i_tx_busy falls.
- Send A5 57, pulse i_rx_error, then a full valid write of 8'h55 to register 0 -> first frame aborted with no response; o_err_cnt = 1; second frame ACKs; o_led = 8'h55.
- Assert i_rst asynchronously between the DATA and CHK bytes; after release send 6B -> all outputs 0, byte ignored in IDLE, no o_tx_valid. With UART_CMD_PARSER_TIMEOUT_EN and TimeoutCycles = 100: send A5 57 then idle 100 cycles -> FSM in IDLE, o_err_cnt = 1.
